// File: rtl/uart_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_mem_loader
//  Purpose  : Receives a length-prefixed byte stream on a UART RX pin (8N1,
//             LSB first) and writes the payload into a byte memory at
//             addresses 0..N-1. The header is a 16-bit little-endian length.
//  Ports    : clk, rst_n      - system clock, async active-low reset
//             rx              - serial input, idle high, asynchronous to clk
//             mem_addr/_write/_data_in - byte-wide memory write port
//             busy            - load in progress (first header byte onward)
//             load_done       - level, set after the final payload write
//             frame_err       - one-cycle pulse per bad stop bit or bad header
//  Revision : 1.0  initial release
// ============================================================================
module uart_mem_loader #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [14:0] mem_addr,
    output logic        mem_write,
    output logic [7:0]  mem_data_in,
    output logic        busy,
    output logic        load_done,
    output logic        frame_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [15:0]      MAX_LEN   = 16'd32768;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; reset to the idle (high) line level so a
    // reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // RX deserializer
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t        rx_state;
    rx_state_t        rx_state_nxt;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             byte_valid;
    logic             cnt_clear;
    logic             sample_bit;
    logic             stop_ok;
    logic             stop_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= R_IDLE;
        else        rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        cnt_clear    = 1'b0;
        sample_bit   = 1'b0;
        stop_ok      = 1'b0;
        stop_bad     = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (!rx_sync) begin
                    rx_state_nxt = R_START;
                    cnt_clear    = 1'b1;
                end
            end
            R_START: begin
                // Mid start bit: a high line here means the low was a glitch.
                if (clk_cnt == HALF_LAST) begin
                    cnt_clear    = 1'b1;
                    rx_state_nxt = rx_sync ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    cnt_clear  = 1'b1;
                    sample_bit = 1'b1;
                    if (bit_cnt == 3'd7) rx_state_nxt = R_STOP;
                end
            end
            R_STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    cnt_clear    = 1'b1;
                    stop_ok      = rx_sync;
                    stop_bad     = !rx_sync;
                    rx_state_nxt = R_IDLE;
                end
            end
            default: rx_state_nxt = R_IDLE;
        endcase
    end

    // The shift register is not touched between the stop-bit sample and the
    // next start bit, so it doubles as the received-byte holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt    <= '0;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= stop_ok;
            if (cnt_clear || rx_state == R_IDLE) clk_cnt <= '0;
            else                                 clk_cnt <= clk_cnt + CNT_W'(1);
            if (rx_state == R_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (sample_bit) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Loader
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {L_HDR_LO, L_HDR_HI, L_PAYLOAD, L_DONE} ld_state_t;

    ld_state_t   ld_state;
    ld_state_t   ld_state_nxt;
    logic [7:0]  len_lo;
    logic [15:0] hdr_len;
    logic [14:0] ptr;
    logic [15:0] remaining;
    logic        take_lo;
    logic        take_hi;
    logic        write_byte;
    logic        finish;

    assign hdr_len = {shift, len_lo};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ld_state <= L_HDR_LO;
        else        ld_state <= ld_state_nxt;
    end

    always_comb begin
        ld_state_nxt = ld_state;
        take_lo      = 1'b0;
        take_hi      = 1'b0;
        write_byte   = 1'b0;
        finish       = 1'b0;
        case (ld_state)
            L_HDR_LO, L_DONE: begin
                if (byte_valid) begin
                    take_lo      = 1'b1;
                    ld_state_nxt = L_HDR_HI;
                end
            end
            L_HDR_HI: begin
                if (byte_valid) begin
                    take_hi = 1'b1;
                    if (hdr_len > MAX_LEN)   ld_state_nxt = L_HDR_LO;
                    else if (hdr_len == 16'd0) ld_state_nxt = L_DONE;
                    else                     ld_state_nxt = L_PAYLOAD;
                end
            end
            L_PAYLOAD: begin
                // remaining reaches zero in the cycle the last write is on
                // the port, so completion lands one cycle after that write.
                if (remaining == 16'd0) begin
                    finish       = 1'b1;
                    ld_state_nxt = L_DONE;
                end else if (byte_valid) begin
                    write_byte = 1'b1;
                end
            end
            default: ld_state_nxt = L_HDR_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo      <= 8'd0;
            ptr         <= 15'd0;
            remaining   <= 16'd0;
            mem_addr    <= 15'd0;
            mem_write   <= 1'b0;
            mem_data_in <= 8'd0;
            busy        <= 1'b0;
            load_done   <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            mem_write <= write_byte;
            frame_err <= stop_bad || (take_hi && hdr_len > MAX_LEN);
            if (take_lo) begin
                len_lo    <= shift;
                busy      <= 1'b1;
                load_done <= 1'b0;
            end
            if (take_hi) begin
                if (hdr_len > MAX_LEN) begin
                    busy <= 1'b0;
                end else if (hdr_len == 16'd0) begin
                    busy      <= 1'b0;
                    load_done <= 1'b1;
                end else begin
                    ptr       <= 15'd0;
                    remaining <= hdr_len;
                end
            end
            if (write_byte) begin
                mem_addr    <= ptr;
                mem_data_in <= shift;
                ptr         <= ptr + 15'd1;
                remaining   <= remaining - 16'd1;
            end
            if (finish) begin
                busy      <= 1'b0;
                load_done <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_mem_loader
//  Purpose  : Self-checking bench for uart_mem_loader. Serial frames are
//             driven on rx; a byte-level reference model predicts the memory
//             writes, frame_err pulses and final busy/load_done levels.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_mem_loader;

    localparam int BIT_CLKS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [14:0] mem_addr;
    logic        mem_write;
    logic [7:0]  mem_data_in;
    logic        busy;
    logic        load_done;
    logic        frame_err;

    uart_mem_loader #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .mem_addr    (mem_addr),
        .mem_write   (mem_write),
        .mem_data_in (mem_data_in),
        .busy        (busy),
        .load_done   (load_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: byte-level view of the load protocol
    // ------------------------------------------------------------------
    logic [22:0] exp_wr[$];
    logic [22:0] act_wr[$];
    int m_phase;      // 0 expect len lo, 1 expect len hi, 2 payload, 3 finished
    int m_len, m_ptr, m_rem, m_ferr;
    bit m_busy, m_done, m_completed, m_zero_len;

    task automatic model_reset();
        m_phase = 0; m_len = 0; m_ptr = 0; m_rem = 0; m_ferr = 0;
        m_busy = 0; m_done = 0; m_completed = 0; m_zero_len = 0;
        exp_wr.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit good);
        logic [14:0] a;
        if (!good) begin
            m_ferr++;
            return;
        end
        if (m_phase == 0 || m_phase == 3) begin
            m_len = int'(b); m_busy = 1; m_done = 0; m_phase = 1;
        end else if (m_phase == 1) begin
            m_len = m_len + int'(b) * 256;
            if (m_len > 32768) begin
                m_ferr++; m_busy = 0; m_phase = 0;
            end else if (m_len == 0) begin
                m_done = 1; m_busy = 0; m_phase = 3; m_completed = 1; m_zero_len = 1;
            end else begin
                m_ptr = 0; m_rem = m_len; m_phase = 2;
            end
        end else begin
            a = 15'(m_ptr);
            exp_wr.push_back({a, b});
            m_ptr++; m_rem--;
            if (m_rem == 0) begin
                m_done = 1; m_busy = 0; m_phase = 3; m_completed = 1; m_zero_len = 0;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Output monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    int  cyc = 0, act_ferr = 0;
    int  last_wr_cyc = 0, ld_rise_cyc = 0, busy_fall_cyc = 0;
    bit  prev_wr = 0, prev_done = 0, prev_busy = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            prev_wr = 0; prev_done = 0; prev_busy = 0;
        end else begin
            if (mem_write) begin
                check("wr_back_to_back", 32'(prev_wr), 32'd0);
                act_wr.push_back({mem_addr, mem_data_in});
                last_wr_cyc = cyc;
            end
            if (frame_err) act_ferr++;
            if (load_done && !prev_done) ld_rise_cyc = cyc;
            if (!busy && prev_busy) busy_fall_cyc = cyc;
            prev_wr = mem_write; prev_done = load_done; prev_busy = busy;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic uart_tx(input logic [7:0] b, input bit good);
        @(negedge clk) rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = good;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit good);
        model_byte(b, good);
        uart_tx(b, good);
    endtask

    task automatic glitch();
        @(negedge clk) rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic verify(input string tag);
        int n;
        repeat (8) @(negedge clk);
        #1;
        check({tag, "_nwr"}, 32'(act_wr.size()), 32'(exp_wr.size()));
        n = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) check({tag, "_wr"}, 32'(act_wr[i]), 32'(exp_wr[i]));
        check({tag, "_ferr"}, 32'(act_ferr), 32'(m_ferr));
        check({tag, "_done"}, 32'(load_done), 32'(m_done));
        check({tag, "_busy"}, 32'(busy), 32'(m_busy));
        if (m_completed) begin
            if (!m_zero_len)
                check({tag, "_done_lat"}, 32'(ld_rise_cyc - last_wr_cyc), 32'd1);
            check({tag, "_busy_fall"}, 32'(busy_fall_cyc), 32'(ld_rise_cyc));
        end
        act_wr.delete(); exp_wr.delete();
        act_ferr = 0; m_ferr = 0; m_completed = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] b;
        int len;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check("rst_addr",  32'(mem_addr),    32'd0);
        check("rst_write", 32'(mem_write),   32'd0);
        check("rst_data",  32'(mem_data_in), 32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_done",  32'(load_done),   32'd0);
        check("rst_ferr",  32'(frame_err),   32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic four-byte load
        send(8'h04, 1); send(8'h00, 1);
        send(8'h41, 1); send(8'h42, 1); send(8'h43, 1); send(8'h44, 1);
        verify("basic");

        // Zero-length load
        send(8'h00, 1); send(8'h00, 1);
        verify("zero");

        // Framing error inside payload, byte resent
        send(8'h02, 1); send(8'h00, 1);
        send(8'h58, 0); send(8'h59, 1); send(8'h5A, 1);
        verify("ferr");

        // Oversized header rejected, then a good load
        send(8'h01, 1); send(8'h81, 1);
        verify("hdr_rej");
        send(8'h01, 1); send(8'h00, 1); send(8'h55, 1);
        verify("after_rej");

        // Short glitches while idle and in the middle of a load
        glitch();
        verify("glitch_idle");
        send(8'h02, 1); glitch(); send(8'h00, 1); glitch();
        send(8'h61, 1); glitch(); send(8'h62, 1);
        verify("glitch_load");

        // Reset in the middle of a payload
        send(8'h04, 1); send(8'h00, 1); send(8'h10, 1); send(8'h11, 1);
        verify("pre_rst");
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid_rst_addr",  32'(mem_addr),    32'd0);
        check("mid_rst_write", 32'(mem_write),   32'd0);
        check("mid_rst_data",  32'(mem_data_in), 32'd0);
        check("mid_rst_busy",  32'(busy),        32'd0);
        check("mid_rst_done",  32'(load_done),   32'd0);
        check("mid_rst_ferr",  32'(frame_err),   32'd0);
        repeat (3) @(negedge clk);
        model_reset();
        act_wr.delete(); act_ferr = 0;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send(8'h01, 1); send(8'h00, 1); send(8'h7A, 1);
        verify("post_rst");

        // Randomized loads with occasional bad bytes, glitches, bad headers
        for (int it = 0; it < 6; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 8'($urandom);
                send(b, 1);
                b = 8'($urandom_range(8'h81, 8'hFF));
                send(b, 1);
            end
            len = $urandom_range(1, 8);
            send(8'(len), 1); send(8'h00, 1);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    b = 8'($urandom);
                    send(b, 0);
                end
                if ($urandom_range(0, 5) == 0) glitch();
                b = 8'($urandom);
                send(b, 1);
            end
            verify("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
